cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning consecutive stable synchronized cycles required before a debounced level changes (1 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 16, meaning debounce counter width; the counter SHALL be able to hold DEBOUNCE_CYCLES.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock (LOGISIM_CLOCK_TREE_0[1] domain); all flops clocked on its rising edge.
REQ-004 SHALL have port NCLR, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port KEY_STEP_N, input, 1 bit: raw board push-button, asynchronous, low = pressed.
REQ-006 SHALL have port SW_RUN, input, 1 bit: raw slide switch, asynchronous, high = free-run requested.
REQ-007 SHALL have port HALT, input, 1 bit: CPU halt indication, synchronous to CLK.
REQ-008 SHALL have port ALWAYS_CPU_EN, output, 1 bit: continuous-run enable to the CPU enable generator.
REQ-009 SHALL have port ONCE_CPU_EN, output, 1 bit: single-cycle single-step request.
REQ-010 SHALL have port RUN_LED, output, 1 bit: high in RUN.
REQ-011 SHALL have port HALTED_LED, output, 1 bit: high in HALTED.
REQ-012 SHALL have port STEP_COUNT, output, 8 bits: number of ONCE_CPU_EN pulses issued since reset.

Function
REQ-013 KEY_STEP_N and SW_RUN SHALL each pass through a 2-flop synchronizer before any other use.
REQ-014 Each synchronized input SHALL feed its own debouncer: counter clears whenever the synchronized value equals the debounced level; otherwise it increments; the debounced level takes the synchronized value on the cycle the counter reaches DEBOUNCE_CYCLES, and the counter then clears.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL NOT change a debounced level.
REQ-016 step_press SHALL be a one-cycle strobe on the debounced key's released-to-pressed transition only; release SHALL generate nothing.
REQ-017 The FSM SHALL have exactly four states: IDLE, RUN, STEP, HALTED.
REQ-018 IDLE: if debounced SW_RUN=1 -> RUN; else if step_press -> STEP; else stay.
REQ-019 Simultaneous switch-high and step_press in IDLE SHALL go to RUN; the step is discarded.
REQ-020 STEP: lasts exactly one cycle and returns to IDLE unconditionally; HALT is ignored.
REQ-021 RUN: if HALT=1 -> HALTED (priority); else if debounced SW_RUN=0 -> IDLE; step_press ignored.
REQ-022 HALTED: step_press ignored; exit to IDLE only when debounced SW_RUN=0 (re-arm); HALT is not required to deassert.
REQ-023 Outputs SHALL be registered and state-decoded: ALWAYS_CPU_EN=1 and RUN_LED=1 exactly in RUN; ONCE_CPU_EN=1 exactly in STEP; HALTED_LED=1 exactly in HALTED.
REQ-024 ALWAYS_CPU_EN and ONCE_CPU_EN SHALL never both be 1.
REQ-025 Latency: ONCE_CPU_EN SHALL assert 2 cycles after the debounced key level changes to pressed (1 cycle strobe, 1 cycle state).
REQ-026 STEP_COUNT SHALL increment by 1 in the cycle ONCE_CPU_EN is 1, modulo 256 (255 -> 0).

Reset
REQ-027 When NCLR=0 at a rising CLK edge: FSM=IDLE; synchronizers and debounced key level = released (1); debounced switch = 0; counters = 0; STEP_COUNT=0; all outputs 0.
REQ-028 Reset mid-RUN or mid-STEP SHALL drop outputs to 0 the next edge; a held-high SW_RUN SHALL re-enter RUN only after re-debouncing (>= DEBOUNCE_CYCLES+3 cycles after NCLR=1).

Structure
REQ-029 State encoding (2-bit IDLE=0, RUN=1, STEP=2, HALTED=3) and the default debounce constant SHALL reside in shared package cpu_ctrl_pkg.
REQ-030 The synchronizer+debouncer SHALL be one sub-module, sync_debounce, instantiated twice.
REQ-031 Total RTL SHALL be 120-400 lines.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-032 Hold KEY_STEP_N low 10 cycles -> exactly one ONCE_CPU_EN pulse, STEP_COUNT 0 -> 1; release -> no pulse.
REQ-033 KEY_STEP_N low for 3 synchronized cycles then high -> no ONCE_CPU_EN, STEP_COUNT stays 0.
REQ-034 SW_RUN=1 -> ALWAYS_CPU_EN=1; HALT=1 one cycle -> HALTED_LED=1, ALWAYS_CPU_EN=0; step press -> ignored; SW_RUN=0 -> IDLE.
REQ-035 Switch rise and step press debounced in the same cycle -> RUN, STEP_COUNT unchanged.
REQ-036 Preload STEP_COUNT=255 via 255 steps, one more step -> STEP_COUNT=0.
REQ-037 NCLR=0 during RUN -> all outputs 0 next edge; SW_RUN held 1 -> RUN regained no earlier than 7 cycles after NCLR=1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/step controller: state encoding,
// default debounce constants and the state-to-output decode.
package cpu_ctrl_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int CNT_W_DEFAULT           = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } run_state_t;

    typedef struct packed {
        logic always_cpu_en;
        logic once_cpu_en;
        logic run_led;
        logic halted_led;
    } run_outputs_t;

    // Outputs depend on the state register only, so they are glitch-free
    // and the two CPU enables can never be active together.
    function automatic run_outputs_t decode_outputs(input run_state_t s);
        run_outputs_t o;
        o               = '0;
        o.always_cpu_en = (s == RUN);
        o.run_led       = (s == RUN);
        o.once_cpu_en   = (s == STEP);
        o.halted_led    = (s == HALTED);
        return o;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board/CPU-side signal bundle of the run controller.
interface cpu_run_ctrl_if;

    logic       KEY_STEP_N;
    logic       SW_RUN;
    logic       HALT;
    logic       ALWAYS_CPU_EN;
    logic       ONCE_CPU_EN;
    logic       RUN_LED;
    logic       HALTED_LED;
    logic [7:0] STEP_COUNT;

    modport master (
        output KEY_STEP_N,
        output SW_RUN,
        output HALT,
        input  ALWAYS_CPU_EN,
        input  ONCE_CPU_EN,
        input  RUN_LED,
        input  HALTED_LED,
        input  STEP_COUNT
    );

    modport slave (
        input  KEY_STEP_N,
        input  SW_RUN,
        input  HALT,
        output ALWAYS_CPU_EN,
        output ONCE_CPU_EN,
        output RUN_LED,
        output HALTED_LED,
        output STEP_COUNT
    );

endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one
// asynchronous board input.
module sync_debounce
    import cpu_ctrl_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int   CNT_W           = CNT_W_DEFAULT,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic nclr,
    input  logic raw,
    output logic level
);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             level_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;

    // The counter only runs while the synchronized value disagrees with the
    // debounced level; any agreeing sample throws the partial count away.
    always_comb begin
        cnt_inc    = cnt_reg + CNT_W'(1);
        cnt_next   = '0;
        level_next = level_reg;
        if (sync2_reg != level_reg) begin
            if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
                level_next = sync2_reg;
            end else begin
                cnt_next = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nclr) begin
            sync1_reg <= RESET_LEVEL;
            sync2_reg <= RESET_LEVEL;
            level_reg <= RESET_LEVEL;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            level_reg <= level_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign level = level_reg;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run / single-step / halt controller: debounces the step key and run
// switch and produces the CPU enable requests plus status LEDs.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic           CLK,
    input  logic           NCLR,
    cpu_run_ctrl_if.slave  bus
);

    // Index 0 is the step key (idles released/high), index 1 the run switch.
    localparam logic [1:0] RESET_LEVELS = 2'b01;

    logic [1:0]   raw_in;
    logic [1:0]   level;
    logic         key_level;
    logic         sw_level;
    logic         key_level_d_reg;
    logic         step_press_reg;
    run_state_t   state_reg;
    run_state_t   state_next;
    logic [7:0]   step_count_reg;
    logic [7:0]   step_count_next;
    run_outputs_t outs;

    assign raw_in = {bus.SW_RUN, bus.KEY_STEP_N};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_input
            sync_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W),
                .RESET_LEVEL     (RESET_LEVELS[gi])
            ) u_sync_debounce (
                .clk   (CLK),
                .nclr  (NCLR),
                .raw   (raw_in[gi]),
                .level (level[gi])
            );
        end
    endgenerate

    assign key_level = level[0];
    assign sw_level  = level[1];

    // Strobe is registered, so a debounced press reaches STEP two edges later.
    always_ff @(posedge CLK) begin
        if (!NCLR) begin
            key_level_d_reg <= 1'b1;
            step_press_reg  <= 1'b0;
            state_reg       <= IDLE;
            step_count_reg  <= '0;
        end else begin
            key_level_d_reg <= key_level;
            step_press_reg  <= key_level_d_reg & ~key_level;
            state_reg       <= state_next;
            step_count_reg  <= step_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        step_count_next = step_count_reg;
        case (state_reg)
            IDLE: begin
                // Switch wins over a coincident press; that press is dropped.
                if (sw_level) begin
                    state_next = RUN;
                end else if (step_press_reg) begin
                    state_next = STEP;
                end
            end
            RUN: begin
                if (bus.HALT) begin
                    state_next = HALTED;
                end else if (!sw_level) begin
                    state_next = IDLE;
                end
            end
            STEP: begin
                state_next      = IDLE;
                step_count_next = step_count_reg + 8'd1;
            end
            HALTED: begin
                // Leaving HALTED needs the operator to turn the switch off.
                if (!sw_level) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign outs              = decode_outputs(state_reg);
    assign bus.ALWAYS_CPU_EN = outs.always_cpu_en;
    assign bus.ONCE_CPU_EN   = outs.once_cpu_en;
    assign bus.RUN_LED       = outs.run_led;
    assign bus.HALTED_LED    = outs.halted_led;
    assign bus.STEP_COUNT    = step_count_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl with a short debounce time; a
// behavioural model predicts every output after every clock edge.
module tb_cpu_run_ctrl;

    localparam int D = 4;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_STEP   = 2;
    localparam int M_HALTED = 3;

    logic CLK = 1'b0;
    logic NCLR;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    // Model state: raw samples of the two previous edges, synchronized
    // sample windows, debounced levels and their recent history.
    bit m_key_pipe [2];
    bit m_sw_pipe  [2];
    bit m_key_win  [$];
    bit m_sw_win   [$];
    bit m_key_lvl;
    bit m_sw_lvl;
    bit m_key_hist [3];
    int m_mode;
    int m_count;

    always #5 CLK = ~CLK;

    cpu_run_ctrl_if bus ();

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4)
    ) dut (
        .CLK  (CLK),
        .NCLR (NCLR),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // A debounced level flips once the last D synchronized samples all disagree with it.
    function automatic bit window_flips(input bit win[$], input bit lvl);
        if (win.size() < D) return 1'b0;
        foreach (win[i]) begin
            if (win[i] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input bit n, input bit k, input bit s, input bit h);
        bit press;
        if (!n) begin
            m_key_pipe = '{1'b1, 1'b1};
            m_sw_pipe  = '{1'b0, 1'b0};
            m_key_win.delete();
            m_sw_win.delete();
            m_key_lvl  = 1'b1;
            m_sw_lvl   = 1'b0;
            m_key_hist = '{1'b1, 1'b1, 1'b1};
            m_mode     = M_IDLE;
            m_count    = 0;
            return;
        end
        // A press is acted on two edges after the debounced key falls.
        press = m_key_hist[2] && !m_key_hist[1];
        case (m_mode)
            M_IDLE:   if (m_sw_lvl) m_mode = M_RUN; else if (press) m_mode = M_STEP;
            M_RUN:    if (h) m_mode = M_HALTED; else if (!m_sw_lvl) m_mode = M_IDLE;
            M_STEP:   begin m_mode = M_IDLE; m_count = (m_count + 1) % 256; end
            default:  if (!m_sw_lvl) m_mode = M_IDLE;
        endcase
        m_key_win.push_back(m_key_pipe[1]);
        if (m_key_win.size() > D) void'(m_key_win.pop_front());
        if (window_flips(m_key_win, m_key_lvl)) m_key_lvl = m_key_pipe[1];
        m_sw_win.push_back(m_sw_pipe[1]);
        if (m_sw_win.size() > D) void'(m_sw_win.pop_front());
        if (window_flips(m_sw_win, m_sw_lvl)) m_sw_lvl = m_sw_pipe[1];
        m_key_hist[2] = m_key_hist[1];
        m_key_hist[1] = m_key_hist[0];
        m_key_hist[0] = m_key_lvl;
        m_key_pipe[1] = m_key_pipe[0];
        m_key_pipe[0] = k;
        m_sw_pipe[1]  = m_sw_pipe[0];
        m_sw_pipe[0]  = s;
    endtask

    task automatic tick();
        bit n, k, s, h;
        n = NCLR;
        k = bus.KEY_STEP_N;
        s = bus.SW_RUN;
        h = bus.HALT;
        @(posedge CLK);
        model_edge(n, k, s, h);
        #1;
        chk("always_cpu_en", 8'(bus.ALWAYS_CPU_EN), 8'(m_mode == M_RUN));
        chk("run_led",       8'(bus.RUN_LED),       8'(m_mode == M_RUN));
        chk("once_cpu_en",   8'(bus.ONCE_CPU_EN),   8'(m_mode == M_STEP));
        chk("halted_led",    8'(bus.HALTED_LED),    8'(m_mode == M_HALTED));
        chk("step_count",    bus.STEP_COUNT,        8'(m_count));
        chk("enables_exclusive", 8'(bus.ALWAYS_CPU_EN & bus.ONCE_CPU_EN), 8'd0);
        if (bus.ONCE_CPU_EN === 1'b1) pulses++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int p0;
        int c0;
        int cyc;

        NCLR           = 1'b0;
        bus.KEY_STEP_N = 1'b1;
        bus.SW_RUN     = 1'b0;
        bus.HALT       = 1'b0;
        ticks(3);
        chk("reset_step_count", bus.STEP_COUNT, 8'd0);
        NCLR = 1'b1;
        ticks(4);

        // Glitch of three synchronized cycles must be filtered out.
        p0 = pulses;
        bus.KEY_STEP_N = 1'b0;
        ticks(3);
        bus.KEY_STEP_N = 1'b1;
        ticks(12);
        chk("glitch_no_pulse", 8'(pulses - p0), 8'd0);
        chk("glitch_count", bus.STEP_COUNT, 8'd0);

        // Held press gives exactly one step; the release gives none.
        p0 = pulses;
        bus.KEY_STEP_N = 1'b0;
        ticks(10);
        chk("press_one_pulse", 8'(pulses - p0), 8'd1);
        bus.KEY_STEP_N = 1'b1;
        ticks(10);
        chk("release_no_pulse", 8'(pulses - p0), 8'd1);
        chk("press_count", bus.STEP_COUNT, 8'd1);

        // Run, halt, ignored step, re-arm.
        bus.SW_RUN = 1'b1;
        for (int i = 0; i < 20 && bus.ALWAYS_CPU_EN !== 1'b1; i++) tick();
        chk("run_reached", 8'(bus.ALWAYS_CPU_EN), 8'd1);
        bus.HALT = 1'b1;
        tick();
        bus.HALT = 1'b0;
        chk("halted_led_set", 8'(bus.HALTED_LED), 8'd1);
        chk("halt_drops_run", 8'(bus.ALWAYS_CPU_EN), 8'd0);
        p0 = pulses;
        bus.KEY_STEP_N = 1'b0;
        ticks(10);
        bus.KEY_STEP_N = 1'b1;
        ticks(10);
        chk("halted_ignores_step", 8'(pulses - p0), 8'd0);
        chk("still_halted", 8'(bus.HALTED_LED), 8'd1);
        bus.SW_RUN = 1'b0;
        ticks(10);
        chk("rearm_idle", 8'(bus.HALTED_LED | bus.RUN_LED), 8'd0);

        // Switch and key debounced together: run wins, no step.
        p0 = pulses;
        c0 = m_count;
        bus.SW_RUN     = 1'b1;
        bus.KEY_STEP_N = 1'b0;
        ticks(12);
        chk("coincident_run", 8'(bus.ALWAYS_CPU_EN), 8'd1);
        chk("coincident_no_step", 8'(pulses - p0), 8'd0);
        chk("coincident_count", bus.STEP_COUNT, 8'(c0));
        bus.SW_RUN     = 1'b0;
        bus.KEY_STEP_N = 1'b1;
        ticks(10);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) bus.KEY_STEP_N = ~bus.KEY_STEP_N;
            if ($urandom_range(0, 9) == 0) bus.SW_RUN = ~bus.SW_RUN;
            bus.HALT = ($urandom_range(0, 7) == 0);
            NCLR     = ($urandom_range(0, 149) != 0);
            tick();
        end
        NCLR           = 1'b1;
        bus.HALT       = 1'b0;
        bus.SW_RUN     = 1'b0;
        bus.KEY_STEP_N = 1'b1;
        ticks(12);

        // Step the counter up to 255, then wrap it.
        for (int i = 0; i < 300 && m_count != 255; i++) begin
            bus.KEY_STEP_N = 1'b0;
            ticks(9);
            bus.KEY_STEP_N = 1'b1;
            ticks(9);
        end
        chk("count_at_255", bus.STEP_COUNT, 8'd255);
        bus.KEY_STEP_N = 1'b0;
        ticks(9);
        bus.KEY_STEP_N = 1'b1;
        ticks(9);
        chk("count_wraps", bus.STEP_COUNT, 8'd0);

        // Reset during RUN, then the held switch must be re-debounced.
        bus.SW_RUN = 1'b1;
        for (int i = 0; i < 20 && bus.ALWAYS_CPU_EN !== 1'b1; i++) tick();
        chk("run_before_reset", 8'(bus.ALWAYS_CPU_EN), 8'd1);
        NCLR = 1'b0;
        tick();
        chk("reset_drops_run", 8'(bus.ALWAYS_CPU_EN | bus.RUN_LED), 8'd0);
        NCLR = 1'b1;
        cyc  = 0;
        for (int i = 0; i < 30 && bus.ALWAYS_CPU_EN !== 1'b1; i++) begin
            tick();
            cyc++;
        end
        chk("run_regained", 8'(bus.ALWAYS_CPU_EN), 8'd1);
        checks++;
        assert (cyc >= D + 3)
        else begin
            failures++;
            $error("FAIL rerun_latency observed=%0d expected>=%0d", cyc, D + 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
